// File: rtl/cache_param_pkg.sv
// Shared types for the far-memory scheduler.
//   t_tq_id / t_cl_address / t_cl : request identifiers and cache-line payload
//   t_fm_opcode / t_fm_req        : request presented to far memory
//   t_miss_entry / t_evict_entry  : queue entry layouts
package cache_param_pkg;

   localparam int TQ_ID_W   = 4;
   localparam int CL_ADDR_W = 20;
   localparam int CL_W      = 128;

   typedef logic [TQ_ID_W-1:0]   t_tq_id;
   typedef logic [CL_ADDR_W-1:0] t_cl_address;
   typedef logic [CL_W-1:0]      t_cl;

   typedef enum logic {
      FM_RD = 1'b0,
      FM_WR = 1'b1
   } t_fm_opcode;

   typedef struct packed {
      logic        valid;
      t_fm_opcode  opcode;
      t_cl_address cl_address;
      t_cl         data;
      t_tq_id      tq_id;
   } t_fm_req;

   typedef struct packed {
      t_tq_id      tq_id;
      t_cl_address cl_address;
   } t_miss_entry;

   typedef struct packed {
      t_cl_address cl_address;
      t_cl         data;
   } t_evict_entry;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } t_sched_state;

   typedef enum logic {
      RR_MISS  = 1'b0,
      RR_EVICT = 1'b1
   } t_rr;

endpackage

// File: rtl/cache_sched_fifo.sv
// Circular FIFO with an extra pointer bit to tell full from empty.
// Also answers "does any occupied slot match cmp_data_i under cmp_mask_i".
//   clk, rst (sync, active-low)
//   push_i/push_data_i : enqueue (dropped when full)
//   pop_i              : dequeue head (ignored when empty)
//   head_o, full_o, empty_o, count_o
//   cmp_data_i, cmp_mask_i, hit_o : occupied-slot match
module cache_sched_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           head_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o,
   input  logic [WIDTH-1:0]           cmp_data_i,
   input  logic [WIDTH-1:0]           cmp_mask_i,
   output logic                       hit_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       wr_ptr_q, rd_ptr_q;
   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic              push_ok, pop_ok;
   logic [DEPTH-1:0]  slot_hit;

   assign count_o = wr_ptr_q - rd_ptr_q;
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end

   // A slot is occupied when its distance from the read pointer is below count.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [AW-1:0] offs;
      assign offs         = AW'(gi) - rd_ptr_q[AW-1:0];
      assign slot_hit[gi] = ({1'b0, offs} < count_o) &&
                            ((mem_q[gi] & cmp_mask_i) == (cmp_data_i & cmp_mask_i));
   end

   assign hit_o = |slot_hit;

endmodule

// File: rtl/cache_fm_sched.sv
// Far-memory request scheduler: buffers fill-read misses and dirty evictions,
// arbitrates them round-robin onto one FM request port, limits outstanding reads.
//   clk, rst (sync, active-low)
//   miss_req_*  : fill-read request from pipe q3
//   evict_req_* : write-back request from pipe q3
//   cache2fm_req / fm_req_ready : FM request handshake
//   fm_rsp_valid : fill-read response pulse
//   sched_stall, sched_overflow : back-pressure and sticky error
//
// state  | meaning
// S_IDLE | output register empty, valid=0
// S_SEND | output register holds a request, valid=1 until accepted
module cache_fm_sched
   import cache_param_pkg::*;
#(
   parameter int MISS_Q_DEPTH       = 4,
   parameter int EVICT_Q_DEPTH      = 2,
   parameter int MAX_RD_OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        miss_req_valid,
   input  t_tq_id      miss_req_tq_id,
   input  t_cl_address miss_req_cl_address,
   input  logic        evict_req_valid,
   input  t_cl_address evict_req_cl_address,
   input  t_cl         evict_req_data,
   output t_fm_req     cache2fm_req,
   input  logic        fm_req_ready,
   input  logic        fm_rsp_valid,
   output logic        sched_stall,
   output logic        sched_overflow
);

   localparam int MCW = $clog2(MISS_Q_DEPTH) + 1;
   localparam int ECW = $clog2(EVICT_Q_DEPTH) + 1;
   localparam int OW  = $clog2(MAX_RD_OUTSTANDING + 1);

   t_sched_state state_q, state_d;
   t_fm_req      req_q, req_d;
   t_rr          rr_q, rr_d;
   logic [OW-1:0] rd_out_q, rd_out_d;
   logic          ovf_q, ovf_d;

   t_miss_entry  miss_push_data, miss_head;
   t_evict_entry evict_push_data, evict_head, evict_cmp_data, evict_cmp_mask;
   logic         miss_full, miss_empty, miss_pop;
   logic         evict_full, evict_empty, evict_pop;
   logic [MCW-1:0] miss_count;
   logic [ECW-1:0] evict_count;
   logic         addr_hit, miss_hit_unused;

   logic         hs, rd_hs, rsp_ok, miss_elig, evict_elig, grant_evict, grant_miss;
   logic [OW:0]  rd_pend;

   assign miss_push_data  = '{tq_id: miss_req_tq_id, cl_address: miss_req_cl_address};
   assign evict_push_data = '{cl_address: evict_req_cl_address, data: evict_req_data};
   assign evict_cmp_data  = '{cl_address: miss_head.cl_address, data: '0};
   assign evict_cmp_mask  = '{cl_address: '1, data: '0};

   cache_sched_fifo #(.WIDTH($bits(t_miss_entry)), .DEPTH(MISS_Q_DEPTH)) u_miss_q (
      .clk, .rst,
      .push_i(miss_req_valid), .push_data_i(miss_push_data), .pop_i(miss_pop),
      .head_o(miss_head), .full_o(miss_full), .empty_o(miss_empty), .count_o(miss_count),
      .cmp_data_i('0), .cmp_mask_i('0), .hit_o(miss_hit_unused)
   );

   cache_sched_fifo #(.WIDTH($bits(t_evict_entry)), .DEPTH(EVICT_Q_DEPTH)) u_evict_q (
      .clk, .rst,
      .push_i(evict_req_valid), .push_data_i(evict_push_data), .pop_i(evict_pop),
      .head_o(evict_head), .full_o(evict_full), .empty_o(evict_empty), .count_o(evict_count),
      .cmp_data_i(evict_cmp_data), .cmp_mask_i(evict_cmp_mask), .hit_o(addr_hit)
   );

   assign hs     = req_q.valid && fm_req_ready;
   assign rd_hs  = hs && (req_q.opcode == FM_RD);
   assign rsp_ok = fm_rsp_valid && (rd_out_q != '0);

   // A read sitting in the output register will be outstanding once accepted,
   // so it counts against the limit already.
   assign rd_pend     = {1'b0, rd_out_q} + (OW+1)'(req_q.valid && (req_q.opcode == FM_RD));
   assign miss_elig   = !miss_empty && (rd_pend < (OW+1)'(MAX_RD_OUTSTANDING));
   assign evict_elig  = !evict_empty;
   // A pending write-back to the same line must reach FM before the fill read.
   assign grant_evict = evict_elig && (!miss_elig || addr_hit || (rr_q == RR_EVICT));
   assign grant_miss  = miss_elig && !grant_evict;

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      rr_d      = rr_q;
      miss_pop  = 1'b0;
      evict_pop = 1'b0;
      if ((state_q == S_IDLE) || fm_req_ready) begin
         if (grant_evict) begin
            state_d          = S_SEND;
            req_d.valid      = 1'b1;
            req_d.opcode     = FM_WR;
            req_d.cl_address = evict_head.cl_address;
            req_d.data       = evict_head.data;
            req_d.tq_id      = '0;
            evict_pop        = 1'b1;
            rr_d             = RR_MISS;
         end else if (grant_miss) begin
            state_d          = S_SEND;
            req_d.valid      = 1'b1;
            req_d.opcode     = FM_RD;
            req_d.cl_address = miss_head.cl_address;
            req_d.data       = '0;
            req_d.tq_id      = miss_head.tq_id;
            miss_pop         = 1'b1;
            rr_d             = RR_EVICT;
         end else begin
            state_d = S_IDLE;
            req_d   = '0;
         end
      end
   end

   always_comb begin
      rd_out_d = rd_out_q;
      if (rd_hs && !rsp_ok)      rd_out_d = rd_out_q + OW'(1);
      else if (!rd_hs && rsp_ok) rd_out_d = rd_out_q - OW'(1);
      ovf_d = ovf_q || (miss_req_valid && miss_full) || (evict_req_valid && evict_full) ||
              (fm_rsp_valid && (rd_out_q == '0));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         req_q    <= '0;
         rr_q     <= RR_MISS;
         rd_out_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         rr_q     <= rr_d;
         rd_out_q <= rd_out_d;
         ovf_q    <= ovf_d;
      end
   end

   assign cache2fm_req   = req_q;
   assign sched_overflow = ovf_q;
   assign sched_stall    = (miss_count >= MCW'(MISS_Q_DEPTH - 1)) ||
                           (evict_count >= ECW'(EVICT_Q_DEPTH - 1));

endmodule

// File: tb/tb_cache_fm_sched.sv
module tb_cache_fm_sched;
   import cache_param_pkg::*;

   localparam int MQD    = 4;
   localparam int EQD    = 2;
   localparam int MAX_RD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        miss_req_valid;
   t_tq_id      miss_req_tq_id;
   t_cl_address miss_req_cl_address;
   logic        evict_req_valid;
   t_cl_address evict_req_cl_address;
   t_cl         evict_req_data;
   t_fm_req     cache2fm_req;
   logic        fm_req_ready;
   logic        fm_rsp_valid;
   logic        sched_stall;
   logic        sched_overflow;

   int chk = 0;
   int err = 0;

   cache_fm_sched #(.MISS_Q_DEPTH(MQD), .EVICT_Q_DEPTH(EQD), .MAX_RD_OUTSTANDING(MAX_RD)) dut (
      .clk(clk), .rst(rst),
      .miss_req_valid(miss_req_valid), .miss_req_tq_id(miss_req_tq_id),
      .miss_req_cl_address(miss_req_cl_address),
      .evict_req_valid(evict_req_valid), .evict_req_cl_address(evict_req_cl_address),
      .evict_req_data(evict_req_data),
      .cache2fm_req(cache2fm_req), .fm_req_ready(fm_req_ready), .fm_rsp_valid(fm_rsp_valid),
      .sched_stall(sched_stall), .sched_overflow(sched_overflow)
   );

   always #5 clk = ~clk;

   // Reference model: queues of pending work, one request slot, read credit count.
   t_miss_entry  mq[$];
   t_evict_entry eq[$];
   t_fm_req      m_out;
   int           m_rd;
   bit           m_ovf;
   bit           m_pri_miss;

   function automatic bit m_stall();
      return (mq.size() >= MQD-1) || (eq.size() >= EQD-1);
   endfunction

   // Advance model by one clock using the current inputs, then clock the DUT.
   task automatic cycle();
      t_fm_req      nxt;
      t_miss_entry  me;
      t_evict_entry ee;
      bit hs, held_rd, m_ok, e_ok, hit, mfull, efull;
      int pick, rd_nxt;
      if (!rst) begin
         mq.delete(); eq.delete();
         m_out = '0; m_rd = 0; m_ovf = 0; m_pri_miss = 1;
      end else begin
         hs      = m_out.valid && fm_req_ready;
         held_rd = m_out.valid && (m_out.opcode == FM_RD);
         mfull   = (mq.size() == MQD);
         efull   = (eq.size() == EQD);
         m_ok    = (mq.size() > 0) && ((m_rd + int'(held_rd)) < MAX_RD);
         e_ok    = (eq.size() > 0);
         hit     = 0;
         if (mq.size() > 0)
            foreach (eq[i]) if (eq[i].cl_address == mq[0].cl_address) hit = 1;
         pick = 0;
         if (e_ok && (!m_ok || hit || !m_pri_miss)) pick = 2;
         else if (m_ok) pick = 1;
         rd_nxt = m_rd;
         if (hs && (m_out.opcode == FM_RD)) rd_nxt++;
         if (fm_rsp_valid) begin
            if (m_rd > 0) rd_nxt--;
            else m_ovf = 1;
         end
         if (!m_out.valid || hs) begin
            nxt = '0;
            if (pick == 2) begin
               ee = eq.pop_front();
               nxt.valid = 1; nxt.opcode = FM_WR; nxt.cl_address = ee.cl_address;
               nxt.data = ee.data; nxt.tq_id = '0;
               m_pri_miss = 1;
            end else if (pick == 1) begin
               me = mq.pop_front();
               nxt.valid = 1; nxt.opcode = FM_RD; nxt.cl_address = me.cl_address;
               nxt.data = '0; nxt.tq_id = me.tq_id;
               m_pri_miss = 0;
            end
            m_out = nxt;
         end
         if (miss_req_valid) begin
            if (mfull) m_ovf = 1;
            else mq.push_back(t_miss_entry'{tq_id: miss_req_tq_id, cl_address: miss_req_cl_address});
         end
         if (evict_req_valid) begin
            if (efull) m_ovf = 1;
            else eq.push_back(t_evict_entry'{cl_address: evict_req_cl_address, data: evict_req_data});
         end
         m_rd = rd_nxt;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      miss_req_valid = 0;
      evict_req_valid = 0;
      fm_rsp_valid = 0;
   endtask

   task automatic push_miss(input int tq, input int addr);
      miss_req_valid = 1;
      miss_req_tq_id = t_tq_id'(tq);
      miss_req_cl_address = t_cl_address'(addr);
   endtask

   task automatic push_evict(input int addr);
      evict_req_valid = 1;
      evict_req_cl_address = t_cl_address'(addr);
      evict_req_data = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic do_reset();
      clr();
      rst = 0;
      cycle();
      cycle();
      rst = 1;
   endtask

   task automatic test_reset();
      rst = 0;
      push_miss(5, 'h77);
      push_evict('h77);
      fm_rsp_valid = 1;
      cycle();
      cycle();
      clr();
      chk++; if (cache2fm_req !== '0) begin err++; $display("FAIL reset_req: got %0h expected 0", cache2fm_req); end
      chk++; if (sched_stall !== 1'b0) begin err++; $display("FAIL reset_stall: got %0b expected 0", sched_stall); end
      chk++; if (sched_overflow !== 1'b0) begin err++; $display("FAIL reset_ovf: got %0b expected 0", sched_overflow); end
      chk++; if (dut.rd_out_q !== '0) begin err++; $display("FAIL reset_cnt: got %0d expected 0", dut.rd_out_q); end
      rst = 1;
      cycle();
      cycle();
      chk++; if (cache2fm_req.valid !== 1'b0) begin err++; $display("FAIL reset_push_ignored: got valid %0b expected 0", cache2fm_req.valid); end
   endtask

   task automatic test_single_miss();
      t_fm_req exp;
      do_reset();
      fm_req_ready = 1;
      push_miss(3, 'h0A5);
      cycle();
      clr();
      chk++; if (cache2fm_req.valid !== 1'b0) begin err++; $display("FAIL single_early: got valid %0b expected 0", cache2fm_req.valid); end
      cycle();
      exp = '{valid: 1'b1, opcode: FM_RD, cl_address: 'h0A5, data: '0, tq_id: 4'd3};
      chk++; if (cache2fm_req !== exp) begin err++; $display("FAIL single_req: got %0h expected %0h", cache2fm_req, exp); end
      cycle();
      chk++; if (dut.rd_out_q !== 3'd1) begin err++; $display("FAIL single_cnt_inc: got %0d expected 1", dut.rd_out_q); end
      chk++; if (cache2fm_req.valid !== 1'b0) begin err++; $display("FAIL single_idle: got valid %0b expected 0", cache2fm_req.valid); end
      fm_rsp_valid = 1;
      cycle();
      clr();
      chk++; if (dut.rd_out_q !== 3'd0) begin err++; $display("FAIL single_cnt_dec: got %0d expected 0", dut.rd_out_q); end
   endtask

   task automatic test_alternate();
      t_fm_opcode  got_op[$];
      t_cl_address got_a[$];
      t_fm_opcode  eo;
      t_cl_address ea;
      t_fm_req     exp;
      do_reset();
      fm_req_ready = 1;
      for (int c = 0; c < 14; c++) begin
         clr();
         if ((c % 2 == 0) && (c < 8)) begin
            push_miss(c/2, 'h200 + c/2);
            push_evict('h300 + c/2);
         end
         if (cache2fm_req.valid && fm_req_ready) begin
            got_op.push_back(cache2fm_req.opcode);
            got_a.push_back(cache2fm_req.cl_address);
         end
         cycle();
      end
      clr();
      chk++; if (got_op.size() != 8) begin err++; $display("FAIL alt_count: got %0d expected 8", got_op.size()); end
      for (int k = 0; k < 8 && k < got_op.size(); k++) begin
         eo = (k % 2 == 0) ? FM_RD : FM_WR;
         ea = t_cl_address'(((k % 2 == 0) ? 'h200 : 'h300) + k/2);
         chk++;
         if (got_op[k] !== eo || got_a[k] !== ea) begin
            err++; $display("FAIL alt_order[%0d]: got op %0d addr %0h expected op %0d addr %0h", k, got_op[k], got_a[k], eo, ea);
         end
      end
      for (int c = 0; c < 4; c++) begin fm_rsp_valid = 1; cycle(); end
      clr();
      chk++; if (dut.rd_out_q !== 3'd0) begin err++; $display("FAIL alt_cnt: got %0d expected 0", dut.rd_out_q); end
      // Payload must stay put while FM is not ready.
      fm_req_ready = 0;
      push_miss(9, 'h2A0);
      cycle();
      clr();
      cycle();
      exp = '{valid: 1'b1, opcode: FM_RD, cl_address: 'h2A0, data: '0, tq_id: 4'd9};
      for (int c = 0; c < 5; c++) begin
         chk++; if (cache2fm_req !== exp) begin err++; $display("FAIL hold_stable[%0d]: got %0h expected %0h", c, cache2fm_req, exp); end
         cycle();
      end
      fm_req_ready = 1;
      cycle();
      fm_rsp_valid = 1;
      cycle();
      clr();
   endtask

   task automatic test_order();
      t_fm_opcode  got_op[$];
      t_cl_address got_a[$];
      do_reset();
      fm_req_ready = 0;
      push_evict('h050);
      cycle();
      clr();
      push_evict('h100);
      cycle();
      clr();
      push_miss(7, 'h100);
      cycle();
      clr();
      cycle();
      fm_req_ready = 1;
      for (int c = 0; c < 6; c++) begin
         if (cache2fm_req.valid && fm_req_ready) begin
            got_op.push_back(cache2fm_req.opcode);
            got_a.push_back(cache2fm_req.cl_address);
         end
         cycle();
      end
      chk++;
      if (got_op.size() != 3) begin
         err++; $display("FAIL order_count: got %0d expected 3", got_op.size());
      end else begin
         if (got_op[1] !== FM_WR || got_a[1] !== 'h100 || got_op[2] !== FM_RD || got_a[2] !== 'h100) begin
            err++; $display("FAIL order_wr_first: got op %0d/%0d addr %0h/%0h expected op 1/0 addr 100/100",
                            got_op[1], got_op[2], got_a[1], got_a[2]);
         end
      end
      fm_rsp_valid = 1;
      cycle();
      clr();
   endtask

   task automatic test_max_outstanding();
      int n_iss;
      t_fm_req exp;
      do_reset();
      fm_req_ready = 1;
      n_iss = 0;
      for (int c = 0; c < 20; c++) begin
         clr();
         if (c < 6) push_miss(c, 'h500 + c);
         if (cache2fm_req.valid && fm_req_ready) n_iss++;
         cycle();
         chk++; if (sched_stall !== m_stall()) begin err++; $display("FAIL max_stall[%0d]: got %0b expected %0b", c, sched_stall, m_stall()); end
      end
      clr();
      chk++; if (n_iss != 4) begin err++; $display("FAIL max_issued: got %0d expected 4", n_iss); end
      chk++; if (dut.rd_out_q !== 3'd4) begin err++; $display("FAIL max_cnt: got %0d expected 4", dut.rd_out_q); end
      push_miss(6, 'h506);
      cycle();
      clr();
      chk++; if (sched_stall !== 1'b1) begin err++; $display("FAIL max_stall_at3: got %0b expected 1", sched_stall); end
      fm_rsp_valid = 1;
      cycle();
      clr();
      cycle();
      exp = '{valid: 1'b1, opcode: FM_RD, cl_address: 'h504, data: '0, tq_id: 4'd4};
      chk++; if (cache2fm_req !== exp) begin err++; $display("FAIL max_fifth: got %0h expected %0h", cache2fm_req, exp); end
      chk++; if (sched_stall !== 1'b0) begin err++; $display("FAIL max_stall_at2: got %0b expected 0", sched_stall); end
   endtask

   task automatic test_overflow();
      t_cl_address got_a[$];
      do_reset();
      fm_req_ready = 0;
      for (int c = 0; c < 6; c++) begin
         clr();
         push_miss(c, 'h400 + c);
         cycle();
      end
      clr();
      chk++; if (sched_overflow !== 1'b1) begin err++; $display("FAIL ovf_set: got %0b expected 1", sched_overflow); end
      chk++; if (sched_stall !== 1'b1) begin err++; $display("FAIL ovf_stall: got %0b expected 1", sched_stall); end
      fm_req_ready = 1;
      cycle();
      fm_req_ready = 0;
      chk++; if (dut.rd_out_q !== 3'd1) begin err++; $display("FAIL ovf_cnt1: got %0d expected 1", dut.rd_out_q); end
      fm_req_ready = 1;
      fm_rsp_valid = 1;
      cycle();
      clr();
      fm_req_ready = 0;
      chk++; if (dut.rd_out_q !== 3'd1) begin err++; $display("FAIL cnt_same_cycle: got %0d expected 1", dut.rd_out_q); end
      chk++; if (cache2fm_req.cl_address !== 'h402) begin err++; $display("FAIL ovf_next: got %0h expected 402", cache2fm_req.cl_address); end
      fm_req_ready = 1;
      for (int c = 0; c < 12; c++) begin
         clr();
         fm_rsp_valid = (m_rd > 0);
         if (cache2fm_req.valid && fm_req_ready) got_a.push_back(cache2fm_req.cl_address);
         cycle();
      end
      clr();
      chk++;
      if (got_a.size() != 3) begin
         err++; $display("FAIL ovf_dropped: got %0d issues expected 3", got_a.size());
      end else if (got_a[0] !== 'h402 || got_a[1] !== 'h403 || got_a[2] !== 'h404) begin
         err++; $display("FAIL ovf_seq: got %0h %0h %0h expected 402 403 404", got_a[0], got_a[1], got_a[2]);
      end
      chk++; if (sched_overflow !== 1'b1) begin err++; $display("FAIL ovf_sticky: got %0b expected 1", sched_overflow); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      fm_req_ready = 1;
      push_miss(1, 'h600);
      cycle();
      clr();
      push_miss(2, 'h601);
      cycle();
      clr();
      cycle();
      fm_req_ready = 0;
      chk++; if (cache2fm_req.valid !== 1'b1 || cache2fm_req.cl_address !== 'h601) begin
         err++; $display("FAIL mid_held: got valid %0b addr %0h expected 1 601", cache2fm_req.valid, cache2fm_req.cl_address); end
      chk++; if (dut.rd_out_q !== 3'd1) begin err++; $display("FAIL mid_cnt_pre: got %0d expected 1", dut.rd_out_q); end
      rst = 0;
      push_miss(3, 'h602);
      push_evict('h603);
      cycle();
      clr();
      chk++; if (cache2fm_req.valid !== 1'b0) begin err++; $display("FAIL mid_valid: got %0b expected 0", cache2fm_req.valid); end
      chk++; if (dut.u_miss_q.empty_o !== 1'b1 || dut.u_evict_q.empty_o !== 1'b1) begin
         err++; $display("FAIL mid_empty: got %0b%0b expected 11", dut.u_miss_q.empty_o, dut.u_evict_q.empty_o); end
      chk++; if (dut.rd_out_q !== 3'd0) begin err++; $display("FAIL mid_cnt: got %0d expected 0", dut.rd_out_q); end
      rst = 1;
      cycle();
      cycle();
      chk++; if (cache2fm_req.valid !== 1'b0) begin err++; $display("FAIL mid_after: got valid %0b expected 0", cache2fm_req.valid); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         clr();
         fm_req_ready = ($urandom_range(0, 2) != 0);
         if (($urandom_range(0, 2) == 0) && (!m_stall() || $urandom_range(0, 30) == 0))
            push_miss($urandom_range(0, 15), $urandom_range(0, 7));
         if (($urandom_range(0, 3) == 0) && (!m_stall() || $urandom_range(0, 30) == 0))
            push_evict($urandom_range(0, 7));
         fm_rsp_valid = (m_rd > 0) && ($urandom_range(0, 3) == 0);
         cycle();
         chk++; if (cache2fm_req !== m_out) begin err++; $display("FAIL rnd_req[%0d]: got %0h expected %0h", c, cache2fm_req, m_out); end
         chk++; if (sched_stall !== m_stall()) begin err++; $display("FAIL rnd_stall[%0d]: got %0b expected %0b", c, sched_stall, m_stall()); end
         chk++; if (sched_overflow !== m_ovf) begin err++; $display("FAIL rnd_ovf[%0d]: got %0b expected %0b", c, sched_overflow, m_ovf); end
      end
      clr();
   endtask

   initial begin
      rst = 0;
      fm_req_ready = 0;
      miss_req_tq_id = '0;
      miss_req_cl_address = '0;
      evict_req_cl_address = '0;
      evict_req_data = '0;
      clr();
      test_reset();
      test_single_miss();
      test_alternate();
      test_order();
      test_max_outstanding();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

endmodule

// File: doc/cache_fm_sched.md
CACHE_FM_SCHED -- requirements
Module: cache_fm_sched

Interface
REQ-001 SHALL have parameter MISS_Q_DEPTH, default 4, meaning number of fill-read requests buffered (power of 2).
REQ-002 SHALL have parameter EVICT_Q_DEPTH, default 2, meaning number of dirty-eviction writes buffered (power of 2).
REQ-003 SHALL have parameter MAX_RD_OUTSTANDING, default 4, meaning the limit on FM fill reads issued and not yet answered.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-low.
REQ-006 SHALL have port miss_req_valid, input, 1, a pipe q3 miss needing a fill read.
REQ-007 SHALL have port miss_req_tq_id, input, t_tq_id, the TQ entry owning the miss.
REQ-008 SHALL have port miss_req_cl_address, input, t_cl_address, the missing cache-line address.
REQ-009 SHALL have port evict_req_valid, input, 1, a pipe q3 dirty victim needing a write-back.
REQ-010 SHALL have port evict_req_cl_address, input, t_cl_address, the victim line address.
REQ-011 SHALL have port evict_req_data, input, t_cl (128), the victim line data.
REQ-012 SHALL have port cache2fm_req, output, t_fm_req {valid, opcode FM_RD/FM_WR, cl_address, data, tq_id}, the FM request.
REQ-013 SHALL have port fm_req_ready, input, 1, FM accepts cache2fm_req when valid&&ready.
REQ-014 SHALL have port fm_rsp_valid, input, 1, the fill-read response pulse from FM (same as fm2cache_rd_rsp.valid).
REQ-015 SHALL have port sched_stall, output, 1, telling the pipe not to issue new lookups.
REQ-016 SHALL have port sched_overflow, output, 1, a sticky push-while-full error flag.

Function
REQ-017 SHALL push {tq_id, cl_address} into the miss queue on miss_req_valid, visible at its head the next cycle.
REQ-018 SHALL push {cl_address, data} into the evict queue on evict_req_valid, visible at its head the next cycle.
REQ-019 SHALL accept a miss and an evict push in the same cycle.
REQ-020 SHALL assert sched_stall when either queue holds >= DEPTH-1 entries, so 1 slot is held for in-flight q3 results.
REQ-021 SHALL drop a push to a full queue, leave the queue unchanged, and set sched_overflow until reset.
REQ-022 SHALL implement a 2-state FSM: S_IDLE (output valid=0) and S_SEND (output register loaded, valid=1).
REQ-023 S_IDLE SHALL go to S_SEND when a winner exists, loading the output register and popping the winner's queue in that same edge; earliest issue is 1 cycle after push (push edge N, valid high from edge N+1).
REQ-024 S_SEND SHALL hold every cache2fm_req field stable until fm_req_ready.
REQ-025 On valid&&ready, S_SEND SHALL load the next winner and stay in S_SEND, or return to S_IDLE if no winner exists (back-to-back issue, no bubble).
REQ-026 Arbitration SHALL be round-robin between miss and evict queue heads; the last-granted pointer updates only on grant.
REQ-027 Ordering override: if the miss head cl_address equals any valid evict queue entry address, the evict head SHALL win regardless of the round-robin pointer.
REQ-028 A miss head SHALL be ineligible while rd_outstanding == MAX_RD_OUTSTANDING.
REQ-029 The rd_outstanding counter SHALL +1 on FM_RD handshake, -1 on fm_rsp_valid, and stay unchanged when both happen in the same cycle.
REQ-030 The counter SHALL never wrap: fm_rsp_valid at 0 is ignored and sets sched_overflow.
REQ-031 FM_WR SHALL carry tq_id='0; FM_RD SHALL carry data='0.
REQ-032 Queue pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-033 While rst==0 at a clock edge: FSM=S_IDLE, both queues empty, rd_outstanding=0, RR pointer=miss, cache2fm_req='0, sched_stall=0, sched_overflow=0.
REQ-034 Reset mid-handshake SHALL drop the held request; pushes during reset SHALL be ignored.

Structure
REQ-035 t_fm_req, t_fm_opcode (FM_RD, FM_WR), t_tq_id, t_cl_address and t_cl SHALL live in cache_param_pkg.
REQ-036 Both queues SHALL be instances of one sub-module cache_sched_fifo (parameterised width/depth, push/pop/full/empty/count).

Verification
REQ-037 Single miss tq_id=3, addr 0x0A5, ready=1: FM_RD valid exactly 1 cycle after push; counter=1; fm_rsp_valid -> counter=0.
REQ-038 Miss and evict pushed together, ready=1: grants alternate RD,WR,RD,WR over 4 pushes of each; ready held 0 for 5 cycles -> payload stable.
REQ-039 Evict addr 0x100 queued, then miss addr 0x100 with RR pointing to miss: FM_WR 0x100 issues before FM_RD 0x100.
REQ-040 6 misses, ready=1, no responses: exactly 4 FM_RD issue; after 1 fm_rsp_valid a 5th issues; sched_stall high at count>=3.
REQ-041 Push to a full miss queue -> entry dropped, sched_overflow=1 sticky; RD handshake and fm_rsp_valid in the same cycle -> counter unchanged.
REQ-042 rst=0 asserted while S_SEND is waiting on ready -> next cycle valid=0, queues empty, counter=0.
